hold_decoder: RTL and testbench

Registered binary-to-one-hot decoder with an input handshake and pulse stretching. It accepts binary codes over a valid/ready interface into a 2-entry FIFO and drives each code as a one-hot output held for `HOLD` cycles. A guard gap of `GAP` idle cycles follows each code. It is the receive-side counterpart of the priority encoders: it turns encoded indices (BCD digit, octal, 2-bit) back into select lines for downstream drivers and indicators.

---
 rtl/hold_decoder.sv | 173 +++++++++++++++++
 tb/tb_hold_decoder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hold_decoder.sv
// Registered binary-to-one-hot decoder: a 2-entry input FIFO feeds an
// IDLE/DRIVE/GAP sequencer that holds each code for HOLD cycles plus GAP idle cycles.
module hold_decoder #(
    parameter int IN_W  = 4,
    parameter int OUT_N = 10,
    parameter int HOLD  = 3,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    input  logic             en,
    output logic [OUT_N-1:0] out,
    output logic             out_valid,
    output logic             busy,
    output logic             err,
    output logic [IN_W-1:0]  err_code
);

    localparam int MAXC  = (HOLD > GAP) ? HOLD : GAP;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_M1);
    localparam logic [IN_W:0]    CODE_LIM  = (IN_W+1)'(OUT_N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         count_q, count_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [IN_W-1:0]    fifo_q [2];
    logic [OUT_N-1:0]   out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               err_q, err_d;
    logic [IN_W-1:0]    err_code_q, err_code_d;

    logic               push;
    logic               pop;
    logic               slot_free;
    logic [IN_W-1:0]    head;
    logic               head_ok;

    assign in_ready  = (count_q < 2'd2) & rst_n;
    assign push      = in_valid & in_ready;
    assign head      = fifo_q[rd_ptr_q];
    assign head_ok   = {1'b0, head} < CODE_LIM;

    // The sequencer may take a new code when idle or on the final count of
    // the last phase of the current code (back-to-back reload).
    always_comb begin
        slot_free = 1'b0;
        case (state_q)
            S_IDLE:  slot_free = 1'b1;
            S_DRIVE: slot_free = (cnt_q == '0) && (GAP == 0);
            S_GAP:   slot_free = (cnt_q == '0);
            default: slot_free = 1'b0;
        endcase
    end

    assign pop = en & (count_q != 2'd0) & slot_free;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;
        err_code_d  = err_code_q;

        if (en) begin
            case (state_q)
                S_DRIVE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (GAP > 0) begin
                        state_d     = S_GAP;
                        cnt_d       = GAP_LOAD;
                        out_d       = '0;
                        out_valid_d = 1'b0;
                    end else begin
                        state_d     = S_IDLE;
                        out_d       = '0;
                        out_valid_d = 1'b0;
                    end
                end
                S_GAP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: ;
            endcase
        end

        if (pop) begin
            if (head_ok) begin
                state_d     = S_DRIVE;
                cnt_d       = HOLD_LOAD;
                out_d       = OUT_N'(1) << head;
                out_valid_d = 1'b1;
            end else begin
                state_d    = S_IDLE;
                err_d      = 1'b1;
                err_code_d = head;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            count_q     <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= in_code;
        end
    end

    // The latched code survives a pause; only the visible outputs are masked.
    assign out       = out_q & {OUT_N{en}};
    assign out_valid = out_valid_q & en;
    assign busy      = (state_q != S_IDLE) | (count_q != 2'd0);
    assign err       = err_q;
    assign err_code  = err_code_q;

    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(out_q));
    assert property (@(posedge clk) disable iff (!rst_n) count_q <= 2'd2);
    assert property (@(posedge clk) disable iff (!rst_n) err_q |-> !out_valid_q);

endmodule

// File: tb/tb_hold_decoder.sv
// Bench for hold_decoder: GAP=0 and GAP=1 builds driven in parallel, directed
// vector table, hand sequences and random traffic against a queue-based model.
module tb_hold_decoder;

    localparam int HOLD_C = 3;
    localparam int OUTN_C = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_code;
    logic       en;

    logic       rdy   [2];
    logic [9:0] dout  [2];
    logic       dov   [2];
    logic       dbusy [2];
    logic       derr  [2];
    logic [3:0] dec   [2];

    always #5 clk = ~clk;

    hold_decoder #(.IN_W(4), .OUT_N(10), .HOLD(3), .GAP(0)) u_gap0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_code(in_code), .en(en), .out(dout[0]), .out_valid(dov[0]),
        .busy(dbusy[0]), .err(derr[0]), .err_code(dec[0])
    );

    hold_decoder #(.IN_W(4), .OUT_N(10), .HOLD(3), .GAP(1)) u_gap1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_code(in_code), .en(en), .out(dout[1]), .out_valid(dov[1]),
        .busy(dbusy[1]), .err(derr[1]), .err_code(dec[1])
    );

    int n_pass  = 0;
    int n_total = 0;
    bit mdl_on  = 1'b0;

    // Reference model, index k is the build with GAP = k.
    int mq    [2][2];
    int mn    [2];
    int mhold [2];
    int mgap  [2];
    int mcur  [2];
    int merr  [2];
    int mec   [2];

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s dut_gap%0d t=%0t: got 0x%0h, expected 0x%0h", name, k, $time, act, exp);
    endtask

    task automatic model_check();
        for (int k = 0; k < 2; k++) begin
            int eo;
            eo = (en && mhold[k] > 0) ? (1 << mcur[k]) : 0;
            chk("m_out",       k, int'(dout[k]),  eo);
            chk("m_out_valid", k, int'(dov[k]),   (en && mhold[k] > 0) ? 1 : 0);
            chk("m_busy",      k, int'(dbusy[k]), (mhold[k] > 0 || mgap[k] > 0 || mn[k] > 0) ? 1 : 0);
            chk("m_err",       k, int'(derr[k]),  merr[k]);
            chk("m_err_code",  k, int'(dec[k]),   mec[k]);
            chk("m_in_ready",  k, int'(rdy[k]),   (rst_n && mn[k] < 2) ? 1 : 0);
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                mn[k] = 0; mhold[k] = 0; mgap[k] = 0; merr[k] = 0; mec[k] = 0; mcur[k] = 0;
            end else begin
                bit acc;
                acc = in_valid && (mn[k] < 2);
                merr[k] = 0;
                if (en) begin
                    if (mhold[k] > 0) begin
                        mhold[k]--;
                        if (mhold[k] == 0) mgap[k] = k;
                    end else if (mgap[k] > 0) begin
                        mgap[k]--;
                    end
                    if (mhold[k] == 0 && mgap[k] == 0 && mn[k] > 0) begin
                        int c;
                        c = mq[k][0];
                        mq[k][0] = mq[k][1];
                        mn[k]--;
                        if (c < OUTN_C) begin
                            mcur[k]  = c;
                            mhold[k] = HOLD_C;
                        end else begin
                            merr[k] = 1;
                            mec[k]  = c;
                        end
                    end
                end
                if (acc) begin
                    mq[k][mn[k]] = int'(in_code);
                    mn[k]++;
                end
            end
        end
    endtask

    task automatic cyc_begin(input logic r, input logic v, input logic [3:0] c, input logic e);
        rst_n = r; in_valid = v; in_code = c; en = e;
        @(negedge clk);
        if (mdl_on) model_check();
    endtask

    task automatic cyc_end();
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        logic       r;
        logic       v;
        logic [3:0] c;
        logic       e;
        logic [9:0] o;
        logic       ov;
        logic       rdy;
        logic       busy;
        logic       err;
        logic [3:0] ec;
    } vec_t;

    vec_t tbl [23];
    int   exp_b2b [12];
    int   exp_g0  [8];
    int   exp_g1  [8];

    initial begin
        // Directed sequence for the GAP=1 build, one row per cycle.
        tbl[0]  = '{1'b0, 1'b0, 4'd0,  1'b1, 10'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{1'b1, 1'b1, 4'd3,  1'b1, 10'd0,  1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[2]  = '{1'b1, 1'b0, 4'd0,  1'b1, 10'd0,  1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
        tbl[3]  = '{1'b1, 1'b0, 4'd0,  1'b1, 10'd8,  1'b1, 1'b1, 1'b1, 1'b0, 4'd0};
        tbl[4]  = '{1'b1, 1'b0, 4'd0,  1'b1, 10'd8,  1'b1, 1'b1, 1'b1, 1'b0, 4'd0};
        tbl[5]  = '{1'b1, 1'b0, 4'd0,  1'b1, 10'd8,  1'b1, 1'b1, 1'b1, 1'b0, 4'd0};
        tbl[6]  = '{1'b1, 1'b0, 4'd0,  1'b1, 10'd0,  1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
        tbl[7]  = '{1'b1, 1'b1, 4'd12, 1'b1, 10'd0,  1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[8]  = '{1'b1, 1'b1, 4'd5,  1'b1, 10'd0,  1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
        tbl[9]  = '{1'b1, 1'b0, 4'd0,  1'b1, 10'd0,  1'b0, 1'b1, 1'b1, 1'b1, 4'd12};
        tbl[10] = '{1'b1, 1'b0, 4'd0,  1'b1, 10'd32, 1'b1, 1'b1, 1'b1, 1'b0, 4'd12};
        tbl[11] = '{1'b1, 1'b0, 4'd0,  1'b1, 10'd32, 1'b1, 1'b1, 1'b1, 1'b0, 4'd12};
        tbl[12] = '{1'b1, 1'b0, 4'd0,  1'b1, 10'd32, 1'b1, 1'b1, 1'b1, 1'b0, 4'd12};
        tbl[13] = '{1'b1, 1'b0, 4'd0,  1'b1, 10'd0,  1'b0, 1'b1, 1'b1, 1'b0, 4'd12};
        tbl[14] = '{1'b1, 1'b1, 4'd4,  1'b1, 10'd0,  1'b0, 1'b1, 1'b0, 1'b0, 4'd12};
        tbl[15] = '{1'b1, 1'b0, 4'd0,  1'b1, 10'd0,  1'b0, 1'b1, 1'b1, 1'b0, 4'd12};
        tbl[16] = '{1'b1, 1'b0, 4'd0,  1'b1, 10'd16, 1'b1, 1'b1, 1'b1, 1'b0, 4'd12};
        tbl[17] = '{1'b1, 1'b0, 4'd0,  1'b0, 10'd0,  1'b0, 1'b1, 1'b1, 1'b0, 4'd12};
        tbl[18] = '{1'b1, 1'b0, 4'd0,  1'b0, 10'd0,  1'b0, 1'b1, 1'b1, 1'b0, 4'd12};
        tbl[19] = '{1'b1, 1'b0, 4'd0,  1'b1, 10'd16, 1'b1, 1'b1, 1'b1, 1'b0, 4'd12};
        tbl[20] = '{1'b1, 1'b0, 4'd0,  1'b1, 10'd16, 1'b1, 1'b1, 1'b1, 1'b0, 4'd12};
        tbl[21] = '{1'b1, 1'b0, 4'd0,  1'b1, 10'd0,  1'b0, 1'b1, 1'b1, 1'b0, 4'd12};
        tbl[22] = '{1'b1, 1'b0, 4'd0,  1'b1, 10'd0,  1'b0, 1'b1, 1'b0, 1'b0, 4'd12};

        exp_b2b = '{2, 2, 2, 0, 128, 128, 128, 0, 512, 512, 512, 0};
        exp_g0  = '{1, 1, 1, 4, 4, 4, 0, 0};
        exp_g1  = '{1, 1, 1, 0, 4, 4, 4, 0};

        rst_n = 1'b0; in_valid = 1'b0; in_code = 4'd0; en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc_begin(1'b0, 1'b0, 4'd0, 1'b1);
            cyc_end();
        end
        mdl_on = 1'b1;

        for (int i = 0; i < 23; i++) begin
            cyc_begin(tbl[i].r, tbl[i].v, tbl[i].c, tbl[i].e);
            chk("tbl_out",       1, int'(dout[1]),  int'(tbl[i].o));
            chk("tbl_out_valid", 1, int'(dov[1]),   int'(tbl[i].ov));
            chk("tbl_in_ready",  1, int'(rdy[1]),   int'(tbl[i].rdy));
            chk("tbl_busy",      1, int'(dbusy[1]), int'(tbl[i].busy));
            chk("tbl_err",       1, int'(derr[1]),  int'(tbl[i].err));
            chk("tbl_err_code",  1, int'(dec[1]),   int'(tbl[i].ec));
            cyc_end();
        end

        // Back-to-back 1, 7, 9: the third push fills the FIFO.
        cyc_begin(1'b1, 1'b1, 4'd1, 1'b1); cyc_end();
        cyc_begin(1'b1, 1'b1, 4'd7, 1'b1); cyc_end();
        for (int i = 0; i < 12; i++) begin
            cyc_begin(1'b1, i == 0, (i == 0) ? 4'd9 : 4'd0, 1'b1);
            chk("b2b_out", 1, int'(dout[1]), exp_b2b[i]);
            chk("b2b_onehot", 1, ($countones(dout[1]) <= 1) ? 1 : 0, 1);
            if (i == 0) chk("b2b_ready_before_fill", 1, int'(rdy[1]), 1);
            if (i == 1) chk("b2b_ready_full", 1, int'(rdy[1]), 0);
            cyc_end();
        end

        for (int i = 0; i < 4; i++) begin cyc_begin(1'b1, 1'b0, 4'd0, 1'b1); cyc_end(); end

        // 0 then 2: no zero cycle between codes in the GAP=0 build.
        cyc_begin(1'b1, 1'b1, 4'd0, 1'b1); cyc_end();
        cyc_begin(1'b1, 1'b1, 4'd2, 1'b1); cyc_end();
        for (int i = 0; i < 8; i++) begin
            cyc_begin(1'b1, 1'b0, 4'd0, 1'b1);
            chk("gap0_out", 0, int'(dout[0]), exp_g0[i]);
            chk("gap1_out", 1, int'(dout[1]), exp_g1[i]);
            cyc_end();
        end

        for (int i = 0; i < 4; i++) begin cyc_begin(1'b1, 1'b0, 4'd0, 1'b1); cyc_end(); end

        // Reset while driving code 6 with 8 and 3 still queued.
        cyc_begin(1'b1, 1'b1, 4'd6, 1'b1); cyc_end();
        cyc_begin(1'b1, 1'b1, 4'd8, 1'b1); cyc_end();
        cyc_begin(1'b1, 1'b1, 4'd3, 1'b1); cyc_end();
        cyc_begin(1'b0, 1'b0, 4'd0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            chk("rst_pre_out",   k, int'(dout[k]),  64);
            chk("rst_pre_busy",  k, int'(dbusy[k]), 1);
            chk("rst_in_ready",  k, int'(rdy[k]),   0);
        end
        cyc_end();
        cyc_begin(1'b0, 1'b0, 4'd0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            chk("rst_out",      k, int'(dout[k]),  0);
            chk("rst_busy",     k, int'(dbusy[k]), 0);
            chk("rst_in_ready", k, int'(rdy[k]),   0);
        end
        cyc_end();
        for (int i = 0; i < 10; i++) begin
            cyc_begin(1'b1, 1'b0, 4'd0, 1'b1);
            for (int k = 0; k < 2; k++) begin
                chk("post_rst_out",   k, int'(dout[k]),  0);
                chk("post_rst_busy",  k, int'(dbusy[k]), 0);
                chk("post_rst_ready", k, int'(rdy[k]),   1);
            end
            cyc_end();
        end

        // Random traffic, including invalid codes, pauses and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic       r, v, e;
            logic [3:0] c;
            r = ($urandom_range(0, 199) != 0);
            v = 1'($urandom_range(0, 1));
            c = 4'($urandom_range(0, 15));
            e = ($urandom_range(0, 4) != 0);
            cyc_begin(r, v, c, e);
            cyc_end();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
